// File: rtl/vx_dcache_responder.sv
// Data-cache responder: multi-lane load/store batches against a local
// word memory, with fixed-latency, credit-limited, in-order load responses.
module vx_dcache_responder #(
    parameter int NUM_REQS       = 4,
    parameter int WORD_SIZE      = 4,
    parameter int ADDR_WIDTH     = 30,
    parameter int MEM_WORDS      = 1024,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS-1:0]                 req_valid,
    input  logic [NUM_REQS-1:0]                 req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]       req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQS*WORD_SIZE*8-1:0]     req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]       req_tag,
    output logic [NUM_REQS-1:0]                 req_ready,
    output logic                                rsp_valid,
    output logic [NUM_REQS-1:0]                 rsp_tmask,
    output logic [NUM_REQS*WORD_SIZE*8-1:0]     rsp_data,
    output logic [TAG_WIDTH-1:0]                rsp_tag,
    input  logic                                rsp_ready
);

    localparam int DW = WORD_SIZE * 8;
    localparam int IW = $clog2(MEM_WORDS);
    localparam int OW = $clog2(RSP_QUEUE_SIZE + 1);
    localparam int PW = $clog2(RSP_QUEUE_SIZE);

    typedef struct packed {
        logic [NUM_REQS-1:0]    tmask;
        logic [NUM_REQS*DW-1:0] data;
        logic [TAG_WIDTH-1:0]   tag;
    } rsp_t;

    logic [DW-1:0] mem [MEM_WORDS];

    logic          ready_en_q;
    logic [OW-1:0] out_q, out_d;
    logic          accept, pop, has_ld;
    logic [NUM_REQS-1:0] ld_mask, st_mask;
    rsp_t          rd_rsp;

    logic          pipe_v_q [LATENCY];
    rsp_t          pipe_q   [LATENCY];

    rsp_t          fifo_q [RSP_QUEUE_SIZE];
    logic [PW-1:0] wr_q, rd_q;
    logic [OW-1:0] cnt_q;
    logic          head_v_q;
    rsp_t          head_q;

    logic          in_v, head_load, fpop, push;
    rsp_t          in_d;
    logic          unused_addr;

    assign unused_addr = ^req_addr;

    assign req_ready = {NUM_REQS{ready_en_q && (out_q < OW'(RSP_QUEUE_SIZE))}};
    assign ld_mask   = req_valid & ~req_rw;
    assign st_mask   = req_valid & req_rw;
    assign has_ld    = |ld_mask;
    assign accept    = (|req_valid) && req_ready[0];
    assign pop       = head_v_q && rsp_ready;

    assign rsp_valid = head_v_q;
    assign rsp_tmask = head_q.tmask;
    assign rsp_data  = head_q.data;
    assign rsp_tag   = head_q.tag;

    // Downward scan leaves the tag of the lowest-indexed load lane.
    always_comb begin
        rd_rsp       = '0;
        rd_rsp.tmask = ld_mask;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (ld_mask[i]) begin
                rd_rsp.data[i*DW +: DW] = mem[req_addr[i*ADDR_WIDTH +: IW]];
                rd_rsp.tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Ascending lane order lets the highest lane win each byte.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                for (int b = 0; b < WORD_SIZE; b++) begin
                    if (st_mask[i] && req_byteen[i*WORD_SIZE + b]) begin
                        mem[req_addr[i*ADDR_WIDTH +: IW]][b*8 +: 8]
                            <= req_data[(i*WORD_SIZE + b)*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        out_d = out_q + OW'(accept && has_ld) - OW'(pop);
    end

    assign in_v      = pipe_v_q[LATENCY-1];
    assign in_d      = pipe_q[LATENCY-1];
    assign head_load = !head_v_q || pop;
    assign fpop      = head_load && (cnt_q != '0);
    assign push      = in_v && !(head_load && (cnt_q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            out_q      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_q[i]   <= '0;
            end
            for (int i = 0; i < RSP_QUEUE_SIZE; i++) begin
                fifo_q[i] <= '0;
            end
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            head_v_q <= 1'b0;
            head_q   <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            out_q       <= out_d;
            pipe_v_q[0] <= accept && has_ld;
            pipe_q[0]   <= rd_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_q[i]   <= pipe_q[i-1];
            end
            if (head_load) begin
                if (cnt_q != '0) begin
                    head_v_q <= 1'b1;
                    head_q   <= fifo_q[rd_q];
                end else if (in_v) begin
                    head_v_q <= 1'b1;
                    head_q   <= in_d;
                end else begin
                    head_v_q <= 1'b0;
                    head_q   <= '0;
                end
            end
            if (push) begin
                fifo_q[wr_q] <= in_d;
                wr_q         <= wr_q + 1'b1;
            end
            if (fpop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + OW'(push) - OW'(fpop);
        end
    end

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Directed bench for vx_dcache_responder with a queue-based reference
// model checked every cycle plus literal spot checks.
module tb_vx_dcache_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_rw, req_ready;
    logic [15:0]  req_byteen;
    logic [119:0] req_addr;
    logic [127:0] req_data, rsp_data;
    logic [31:0]  req_tag;
    logic         rsp_valid, rsp_ready;
    logic [3:0]   rsp_tmask;
    logic [7:0]   rsp_tag;

    vx_dcache_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_byteen (req_byteen),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_tag    (req_tag),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_tmask  (rsp_tmask),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .rsp_ready  (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   tmask;
        logic [127:0] data;
        logic [7:0]   tag;
        int           acc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic        rdy_en_m = 1'b0;
    logic [31:0] mem_m [1024];
    exp_t        q[$];
    logic [7:0]  seen[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: responses become visible LATENCY edges after accept,
    // strictly in order, and the credit limit is the queue occupancy.
    always @(posedge clk or negedge reset) begin : model
        logic       rdy, pp;
        logic [3:0] ld;
        exp_t       e;
        if (!reset) begin
            q.delete();
            rdy_en_m = 1'b0;
        end else begin
            rdy = rdy_en_m && (q.size() < 4);
            pp  = (q.size() > 0) && (cyc >= q[0].acc + 2) && rsp_ready;
            if (pp) void'(q.pop_front());
            if (rdy && (|req_valid)) begin
                ld      = req_valid & ~req_rw;
                e.tmask = ld;
                e.data  = '0;
                e.tag   = '0;
                e.acc   = cyc + 1;
                for (int i = 3; i >= 0; i--) begin
                    if (ld[i]) begin
                        e.data[i*32 +: 32] = mem_m[req_addr[i*30 +: 10]];
                        e.tag = req_tag[i*8 +: 8];
                    end
                end
                for (int i = 0; i < 4; i++)
                    for (int b = 0; b < 4; b++)
                        if (req_valid[i] && req_rw[i] && req_byteen[i*4+b])
                            mem_m[req_addr[i*30 +: 10]][b*8 +: 8] =
                                req_data[i*32 + b*8 +: 8];
                if (|ld) q.push_back(e);
            end
            rdy_en_m = 1'b1;
            cyc++;
        end
    end

    initial begin : compare
        logic ev;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ev = reset && (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("m_ready", req_ready,
                {4{reset && rdy_en_m && (q.size() < 4)}});
            chk("m_valid", rsp_valid, ev);
            if (ev) begin
                chk("m_tmask", rsp_tmask, q[0].tmask);
                chk("m_data", rsp_data, q[0].data);
                chk("m_tag", rsp_tag, q[0].tag);
            end else if (!reset) begin
                chk("m_rst_out", {rsp_tmask, rsp_tag, rsp_data}, '0);
            end
            if (rsp_valid && rsp_ready) seen.push_back(rsp_tag);
        end
    end

    task automatic idle();
        req_valid  = '0;
        req_rw     = '0;
        req_byteen = '0;
        req_addr   = '0;
        req_data   = '0;
        req_tag    = '0;
    endtask

    task automatic issue(input logic [3:0] v, input logic [3:0] rw,
                         input logic [15:0] be, input logic [119:0] a,
                         input logic [127:0] d, input logic [31:0] t);
        req_valid  = v;
        req_rw     = rw;
        req_byteen = be;
        req_addr   = a;
        req_data   = d;
        req_tag    = t;
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        idle();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        wait_cyc(3);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", rsp_data, 0);
        reset = 1'b1;
        wait_cyc(1);
        chk("ready_after_rst", req_ready, 4'hF);

        issue(4'b0001, 4'b0001, 16'h000F, {4{30'h10}},
              {96'h0, 32'hDEADBEEF}, 32'h0);
        issue(4'hF, 4'h0, 16'h0, {4{30'h10}}, 128'h0,
              {8'h44, 8'h33, 8'h22, 8'h5A});
        wait_cyc(1);
        chk("basic_early", rsp_valid, 0);
        wait_cyc(1);
        chk("basic_valid", rsp_valid, 1);
        chk("basic_tmask", rsp_tmask, 4'hF);
        chk("basic_data", rsp_data, {4{32'hDEADBEEF}});
        chk("basic_tag", rsp_tag, 8'h5A);

        issue(4'b0001, 4'b0001, 16'h0005, {4{30'h10}},
              {96'h0, 32'h11223344}, 32'h0);
        issue(4'b0100, 4'h0, 16'h0, {4{30'h10}}, 128'h0, 32'h0007_0000);
        wait_cyc(2);
        chk("byteen_tmask", rsp_tmask, 4'b0100);
        chk("byteen_data", rsp_data[95:64], 32'hDE22BE44);
        chk("byteen_tag", rsp_tag, 8'h07);

        issue(4'b0001, 4'b0001, 16'h000F, {4{30'h3}}, 128'h0, 32'h0);
        issue(4'b0111, 4'b0101, 16'h0F0F, {4{30'h3}},
              {32'h0, 32'h55555555, 32'h0, 32'hAAAAAAAA},
              {8'h00, 8'hB2, 8'hB1, 8'hB0});
        wait_cyc(2);
        chk("rbw_tmask", rsp_tmask, 4'b0010);
        chk("rbw_data", rsp_data, 128'h0);
        chk("rbw_tag", rsp_tag, 8'hB1);
        issue(4'b0001, 4'h0, 16'h0, {4{30'h3}}, 128'h0, 32'hC0);
        wait_cyc(2);
        chk("conflict_data", rsp_data[31:0], 32'h55555555);

        issue(4'b0001, 4'b0001, 16'h000F, {4{30'h400}},
              {96'h0, 32'hCAFEF00D}, 32'h0);
        issue(4'b1000, 4'h0, 16'h0, {4{30'h0}}, 128'h0, 32'hD300_0000);
        wait_cyc(2);
        chk("wrap_data", rsp_data[127:96], 32'hCAFEF00D);
        chk("wrap_tag", rsp_tag, 8'hD3);
        wait_cyc(3);

        rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            req_valid = 4'b0001;
            req_addr  = {4{30'h10}};
            req_tag   = k;
            @(posedge clk);
            #2;
        end
        idle();
        chk("bp_ready", req_ready, 4'h0);
        chk("bp_head", rsp_tag, 8'd1);
        wait_cyc(3);
        chk("bp_stable_v", rsp_valid, 1);
        chk("bp_stable_t", rsp_tag, 8'd1);
        seen.delete();
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_addr  = {4{30'h10}};
        req_tag   = 32'd5;
        wait_cyc(1);
        chk("bp_ready_back", req_ready, 4'hF);
        wait_cyc(1);
        idle();
        wait_cyc(8);
        chk("bp_seen_n", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            chk("bp_order", seen[i], i + 1);

        issue(4'b0001, 4'h0, 16'h0, {4{30'h10}}, 128'h0, 32'h21);
        issue(4'b0001, 4'h0, 16'h0, {4{30'h10}}, 128'h0, 32'h22);
        wait_cyc(1);
        chk("mid_valid", rsp_valid, 1);
        chk("mid_tag", rsp_tag, 8'h21);
        reset = 1'b0;
        #1;
        chk("async_valid", rsp_valid, 0);
        chk("async_ready", req_ready, 0);
        chk("async_tag", rsp_tag, 0);
        wait_cyc(2);
        reset = 1'b1;
        chk("rel_ready0", req_ready, 0);
        wait_cyc(1);
        chk("rel_ready1", req_ready, 4'hF);
        wait_cyc(4);
        chk("no_stale", rsp_valid, 0);
        issue(4'b0011, 4'h0, 16'h0, {60'h0, 30'h3, 30'h10}, 128'h0,
              32'h0000_3231);
        wait_cyc(2);
        chk("retain_data", rsp_data[63:0], {32'h55555555, 32'hDE22BE44});
        chk("retain_tag", rsp_tag, 8'h31);
        wait_cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
